req_onehot_arbiter: RTL and testbench



---
 rtl/req_onehot_arbiter_if.sv | 42 ++++
 rtl/req_onehot_arbiter.sv | 164 ++++++++++++++++
 tb/tb_req_onehot_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/req_onehot_arbiter_if.sv
// ---------------------------------------------------------------------------
// req_onehot_arbiter_if
// Bundles the request/grant handshake between the request-capture stage and
// its surroundings.
//   req        : 8 request lines, a 0->1 transition is one request event
//   grant      : one-hot winner, 8'h00 whenever grant_valid is low
//   grant_valid: grant holds a valid one-hot winner
//   grant_ack  : consumer accepts the current grant
//   pending    : registered pending-request bitmap
//   overflow   : sticky lost-request flag
//   clear_ovf  : clears overflow
// Modports: slave = the arbiter, master = the requester/consumer side.
// ---------------------------------------------------------------------------
interface req_onehot_arbiter_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic       grant_ack;
    logic [7:0] pending;
    logic       overflow;
    logic       clear_ovf;

    modport slave (
        input  req,
        input  grant_ack,
        input  clear_ovf,
        output grant,
        output grant_valid,
        output pending,
        output overflow
    );

    modport master (
        output req,
        output grant_ack,
        output clear_ovf,
        input  grant,
        input  grant_valid,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/req_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// req_onehot_arbiter
// Edge-detects eight request lines, keeps them as a pending bitmap and picks
// one with a round-robin arbiter. The winner is held as a strictly one-hot
// grant until the consumer acknowledges it.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : req_onehot_arbiter_if.slave (req, grant, grant_valid, grant_ack,
//         pending, overflow, clear_ovf)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module req_onehot_arbiter (
    input  logic                clk,
    input  logic                rst,
    req_onehot_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // First set bit of vec searching start, start+1, ... (mod 8), as one-hot.
    function automatic logic [7:0] rr_pick(input logic [7:0] vec, input logic [2:0] start);
        logic [7:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = 8'h00;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && vec[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    // OR-based one-hot to index encoder, same structure as the downstream encoder.
    function automatic logic [2:0] onehot_idx(input logic [7:0] vec);
        onehot_idx[0] = vec[1] | vec[3] | vec[5] | vec[7];
        onehot_idx[1] = vec[2] | vec[3] | vec[6] | vec[7];
        onehot_idx[2] = vec[4] | vec[5] | vec[6] | vec[7];
    endfunction

    state_e     state_r, state_next_s;
    logic [7:0] req_q_r;
    logic [7:0] pending_r, pending_next_s;
    logic [7:0] grant_r, grant_next_s;
    logic       grant_valid_r, grant_valid_next_s;
    logic       overflow_r, overflow_next_s;
    logic [2:0] ptr_r, ptr_next_s;
    logic [7:0] rise_s;
    logic [7:0] clr_s;
    logic       accept_s;

    // Edge detect, accept decode, pending/overflow/pointer next values.
    always_comb begin
        rise_s   = bus.req & ~req_q_r;
        accept_s = (state_r == ST_GRANT) & bus.grant_ack;
        if (accept_s) begin
            clr_s      = grant_r;
            ptr_next_s = onehot_idx(grant_r) + 3'd1;
        end else begin
            clr_s      = 8'h00;
            ptr_next_s = ptr_r;
        end
        // A rise on a bit being cleared this cycle re-arms it without loss.
        pending_next_s = (pending_r & ~clr_s) | rise_s;
        if ((rise_s & pending_r & ~clr_s) != 8'h00) begin
            overflow_next_s = 1'b1;
        end else if (bus.clear_ovf) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Next-state logic: arbitrate from registered pending only.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != 8'h00) begin
                    state_next_s = ST_GRANT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (accept_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GRANT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered grant outputs.
    always_comb begin
        grant_next_s       = 8'h00;
        grant_valid_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != 8'h00) begin
                    grant_next_s       = rr_pick(pending_r, ptr_r);
                    grant_valid_next_s = 1'b1;
                end else begin
                    grant_next_s       = 8'h00;
                    grant_valid_next_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (accept_s) begin
                    grant_next_s       = 8'h00;
                    grant_valid_next_s = 1'b0;
                end else begin
                    grant_next_s       = grant_r;
                    grant_valid_next_s = 1'b1;
                end
            end
            default: begin
                grant_next_s       = 8'h00;
                grant_valid_next_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q_r       <= 8'h00;
            pending_r     <= 8'h00;
            grant_r       <= 8'h00;
            grant_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
            ptr_r         <= 3'd0;
        end else begin
            req_q_r       <= bus.req;
            pending_r     <= pending_next_s;
            grant_r       <= grant_next_s;
            grant_valid_r <= grant_valid_next_s;
            overflow_r    <= overflow_next_s;
            ptr_r         <= ptr_next_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.pending     = pending_r;
    assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_req_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_onehot_arbiter
// Directed scenarios followed by a random phase. Every cycle the outputs are
// compared against a behavioural model that tracks pending requests as a
// bitmap, the winner as an integer index and the pointer as an integer.
// ---------------------------------------------------------------------------
module tb_req_onehot_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    req_onehot_arbiter_if bus_if ();

    req_onehot_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_req_q;
    logic [7:0] m_pending;
    logic       m_valid;
    logic       m_ovf;
    int         m_gidx;
    int         m_ptr;
    int         obs_grants;
    logic       prev_valid;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [7:0] g);
        logic [7:0] idx;
        idx = 8'h00;
        for (int i = 0; i < 8; i++) if (g[i]) idx = idx | 8'(i);
        return idx;
    endfunction

    function automatic logic [7:0] model_grant();
        logic [7:0] g;
        g = 8'h00;
        if (m_valid) g[m_gidx] = 1'b1;
        return g;
    endfunction

    // One clock: compute model next state from current inputs, step, compare.
    task automatic tick();
        logic [7:0] rise, clr, np, nq;
        logic       nv, no;
        int         ng, npt;
        if (rst) begin
            nq = 8'h00; np = 8'h00; nv = 1'b0; no = 1'b0; ng = 0; npt = 0;
        end else begin
            rise = bus_if.req & ~m_req_q;
            clr  = 8'h00;
            if (m_valid && bus_if.grant_ack) clr[m_gidx] = 1'b1;
            np = (m_pending & ~clr) | rise;
            no = m_ovf;
            if ((rise & m_pending & ~clr) != 8'h00) no = 1'b1;
            else if (bus_if.clear_ovf) no = 1'b0;
            nv  = m_valid;
            ng  = m_gidx;
            npt = m_ptr;
            if (m_valid) begin
                if (bus_if.grant_ack) begin
                    nv  = 1'b0;
                    npt = (m_gidx + 1) % 8;
                end
            end else if (m_pending != 8'h00) begin
                for (int k = 7; k >= 0; k--)
                    if (m_pending[(m_ptr + k) % 8]) ng = (m_ptr + k) % 8;
                nv = 1'b1;
            end
            nq = bus_if.req;
        end
        @(posedge clk);
        #1;
        m_req_q = nq; m_pending = np; m_valid = nv; m_ovf = no; m_gidx = ng; m_ptr = npt;
        if (bus_if.grant_valid && !prev_valid) obs_grants++;
        prev_valid = bus_if.grant_valid;
        chk("m_grant", bus_if.grant, model_grant());
        chk("m_valid", {7'd0, bus_if.grant_valid}, {7'd0, m_valid});
        chk("m_pending", bus_if.pending, m_pending);
        chk("m_overflow", {7'd0, bus_if.overflow}, {7'd0, m_ovf});
    endtask

    task automatic ack_grant();
        bus_if.grant_ack = 1'b1;
        tick();
        bus_if.grant_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, bus_if.grant, 8'h00);
        chk({tag, "_valid"}, {7'd0, bus_if.grant_valid}, 8'h00);
        chk({tag, "_pending"}, bus_if.pending, 8'h00);
        chk({tag, "_ovf"}, {7'd0, bus_if.overflow}, 8'h00);
    endtask

    initial begin
        int         g0;
        logic [7:0] exp_g;
        rst = 1'b1;
        bus_if.req = 8'h00; bus_if.grant_ack = 1'b0; bus_if.clear_ovf = 1'b0;
        m_req_q = 8'h00; m_pending = 8'h00; m_valid = 1'b0; m_ovf = 1'b0;
        m_gidx = 0; m_ptr = 0; obs_grants = 0; prev_valid = 1'b0;

        // Reset and quiet idle
        tick();
        rst = 1'b0;
        chk_reset_vals("reset");
        repeat (10) begin
            tick();
            chk_reset_vals("idle");
        end

        // Single request on bit 5, acked 3 cycles after grant
        bus_if.req = 8'h20;
        tick();
        chk("r5_pending", bus_if.pending, 8'h20);
        chk("r5_no_grant_yet", {7'd0, bus_if.grant_valid}, 8'h00);
        bus_if.req = 8'h00;
        tick();
        chk("r5_grant", bus_if.grant, 8'h20);
        chk("r5_valid", {7'd0, bus_if.grant_valid}, 8'h01);
        repeat (3) begin
            tick();
            chk("r5_hold", bus_if.grant, 8'h20);
        end
        chk("r5_enc", enc(bus_if.grant), 8'd5);
        ack_grant();
        chk("r5_pending_clr", bus_if.pending, 8'h00);
        chk("r5_valid_clr", {7'd0, bus_if.grant_valid}, 8'h00);

        // All eight lines at once after reset, ack immediately
        rst = 1'b1; tick(); rst = 1'b0;
        bus_if.req = 8'hFF;
        tick();
        bus_if.req = 8'h00;
        tick();
        for (int g = 0; g < 8; g++) begin
            exp_g = 8'h01 << g;
            chk("ff_valid", {7'd0, bus_if.grant_valid}, 8'h01);
            chk("ff_order", bus_if.grant, exp_g);
            ack_grant();
            chk("ff_gap", {7'd0, bus_if.grant_valid}, 8'h00);
            tick();
        end
        chk("ff_pending_empty", bus_if.pending, 8'h00);
        chk("ff_no_ovf", {7'd0, bus_if.overflow}, 8'h00);

        // Round-robin wrap: bit 6 leaves ptr at 7, then bits 7 and 1
        bus_if.req = 8'h40; tick(); bus_if.req = 8'h00; tick();
        chk("rr_grant6", bus_if.grant, 8'h40);
        ack_grant();
        bus_if.req = 8'h82; tick(); bus_if.req = 8'h00; tick();
        chk("rr_grant7", bus_if.grant, 8'h80);
        ack_grant();
        tick();
        chk("rr_grant1", bus_if.grant, 8'h02);
        ack_grant();
        chk("rr_ptr", {5'd0, dut.ptr_r}, 8'd2);

        // Lost request events and overflow clear priority
        g0 = obs_grants;
        bus_if.req = 8'h08; tick(); bus_if.req = 8'h00; tick();
        chk("ovf_grant3", bus_if.grant, 8'h08);
        bus_if.req = 8'h08; tick();
        chk("ovf_set", {7'd0, bus_if.overflow}, 8'h01);
        chk("ovf_pending3", bus_if.pending, 8'h08);
        bus_if.req = 8'h00; tick();
        bus_if.req = 8'h08; bus_if.clear_ovf = 1'b1; tick();
        chk("ovf_set_wins", {7'd0, bus_if.overflow}, 8'h01);
        bus_if.req = 8'h00; bus_if.clear_ovf = 1'b0; tick();
        bus_if.clear_ovf = 1'b1; tick(); bus_if.clear_ovf = 1'b0;
        chk("ovf_cleared", {7'd0, bus_if.overflow}, 8'h00);
        ack_grant();
        repeat (5) tick();
        chk("ovf_one_grant", 8'(obs_grants - g0), 8'd1);
        chk("ovf_pending_empty", bus_if.pending, 8'h00);

        // Reset while a grant is held
        bus_if.req = 8'h0C; tick(); bus_if.req = 8'h00; tick();
        chk("mid_grant", bus_if.grant, 8'h04);
        chk("mid_pending", bus_if.pending, 8'h0C);
        bus_if.req = 8'h01;
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_vals("mid_rst");
        g0 = obs_grants;
        tick(); tick();
        chk("post_rst_grant", bus_if.grant, 8'h01);
        ack_grant();
        repeat (6) tick();
        chk("post_rst_one_grant", 8'(obs_grants - g0), 8'd1);
        bus_if.req = 8'h00;
        tick();

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            bus_if.req       = 8'($urandom);
            bus_if.grant_ack = 1'($urandom_range(0, 1));
            bus_if.clear_ovf = ($urandom_range(0, 9) == 0);
            rst              = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; bus_if.grant_ack = 1'b0; bus_if.clear_ovf = 1'b0; bus_if.req = 8'h00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
